multi_line_buffer: RTL and testbench
====================================

Name: multi_line_buffer

Overview:
Parametrised successor to the register-chain line delay. It stores KERNEL_H-1 image lines in read-first block-RAM line stores arranged as a rotating ring. For every accepted pixel it emits a vertical column of KERNEL_H pixels: the current pixel plus the same column from the previous KERNEL_H-1 lines. It feeds the KxK window/convolution stage of the blurring pipeline, and adds frame restart, line tracking and optional zero-padding of the top border.

Parameters:
DATA_W, 8, pixel width in bits
IMG_WIDTH, 512, pixels per line (>=2)
KERNEL_H, 3, rows per output column (>=2); KERNEL_H-1 line stores
PAD_EN, 0, 1 = emit from row 0 with missing upper rows forced to zero; 0 = emit only once KERNEL_H-1 lines are filled

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_sof  in  1  start of frame; restarts column/row tracking
i_data  in  DATA_W  input pixel
i_data_valid  in  1  pixel accepted this cycle
o_data  out  KERNEL_H*DATA_W  column; slice k = row (r-KERNEL_H+1+k), so slice KERNEL_H-1 is the current row
o_data_valid  out  1  o_data holds a valid column
o_col  out  clog2(IMG_WIDTH)  column index of the pixel in o_data
o_eol  out  1  o_data is the last column of a line

Behaviour:
- Reset (i_rst=1 at a clock edge): o_data=0, o_data_valid=0, o_col=0, o_eol=0. Column counter, fill counter and ring select are cleared. Any input in that cycle is ignored. RAM contents are not cleared; the fill counter masks stale data.
- Acceptance: a pixel is taken when i_data_valid=1 and i_rst=0. There is no backpressure.
- Latency: exactly 1 cycle from accepted pixel to o_data/o_data_valid. o_data_valid pulses only in the cycle after an accepted pixel. In cycles with no acceptance, o_data_valid=0 and o_data, o_col and o_eol hold their values.
- Line stores: KERNEL_H-1 stores, each IMG_WIDTH x DATA_W, single port, synchronous read-first.
  - For each accepted pixel at column c, all stores are read at address c.
  - The store at wr_sel (which holds the oldest line) is written with i_data in the same cycle. Read-first returns the old row.
- Rotation: the ring position of each store maps to an output slice, oldest row in slice 0. The input pixel is registered 1 cycle to align with the RAM read and drives slice KERNEL_H-1.
- Column counter: 0..IMG_WIDTH-1, increments per accepted pixel.
  - At IMG_WIDTH-1 it wraps to 0.
  - On wrap, wr_sel advances modulo KERNEL_H-1 and the fill counter increments, saturating at KERNEL_H-1.
- Output valid:
  - PAD_EN=0: o_data_valid follows acceptance only when fill counter = KERNEL_H-1 at acceptance time.
  - PAD_EN=1: o_data_valid follows every acceptance. Slice k is forced to 0 when k < KERNEL_H-1-fill.
- o_eol=1 with o_data_valid when the column was IMG_WIDTH-1.
- i_sof:
  - Clears the column counter, fill counter and wr_sel.
  - If i_data_valid is also high, that pixel is accepted as row 0, column 0.
  - i_sof mid-line discards the partial line.
  - i_rst has priority over i_sof.
- Widths: o_col is sized with clog2(IMG_WIDTH); the fill counter uses clog2(KERNEL_H). No arithmetic on pixel data.

Decomposition:
- Shared package/header: the clog2 constant function, and derived constants COL_W, FILL_W and NUM_STORES = KERNEL_H-1.
- One sub-module, line_ram: a parametrised single-port read-first synchronous RAM (DATA_W, DEPTH). It is instantiated NUM_STORES times in a generate loop.
- Top level holds the counters, ring select, input alignment register and output mux/mask.

Test Plan:
All scenarios use IMG_WIDTH=4, KERNEL_H=3, with pixel value = row*16+col.
- Fill, PAD_EN=0: reset, then stream rows 0-1 continuously. Expect o_data_valid=0 throughout. Next, input row 2 col 0 (0x20). The following cycle shows o_data_valid=1, o_data slices {k2,k1,k0}={0x20,0x10,0x00}, o_col=0.
- Ring wrap: stream rows 0-5. At input row 5 col 3 (0x53), the next cycle shows slices {0x53,0x43,0x33}, o_col=3, o_eol=1. Count 16 valid outputs total for rows 2-5.
- Valid gaps: insert 3 idle cycles between each pixel of row 2. Each output comes exactly 1 cycle after its pixel, o_data_valid=0 during gaps, and data/counters are unchanged by gaps.
- PAD_EN=1: input row 0 col 1 (0x01). Next cycle o_data_valid=1, slices {0x01,0x00,0x00}. Then row 1 col 1 (0x11) gives {0x11,0x01,0x00}.
- i_sof mid-frame: after rows 0-3, assert i_sof with pixel 0xA0 at row 3 col 2.
  - PAD_EN=0: no valid output until the second following full line; then the first column reads {0x..,0x..,0xA0-line}, i.e. new frame data only.
  - PAD_EN=1: the next output is {0xA0,0,0}, with no stale rows.
- Reset mid-operation: assert i_rst with i_data_valid=1 at row 3 col 1. Next cycle o_data_valid=0, o_data=0, o_col=0. Restreaming from row 0 reproduces the fill scenario exactly.

Source files
------------

// File: rtl/multi_line_buffer_pkg.sv
// Shared width helpers for the multi-line buffer and its line stores.
// Derived sizes (COL_W, FILL_W, NUM_STORES) are computed from the instance parameters.
package multi_line_buffer_pkg;

   // Minimum of 1 so single-entry selects and counters still get a real bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      if (w < 1) w = 1;
      return w;
   endfunction

   function automatic int col_w(input int img_width);
      return clog2(img_width);
   endfunction

   function automatic int fill_w(input int kernel_h);
      return clog2(kernel_h);
   endfunction

   function automatic int num_stores(input int kernel_h);
      return kernel_h - 1;
   endfunction

endpackage

// File: rtl/multi_line_buffer_line_ram.sv
// Single-port synchronous read-first line store; read data holds while i_en is low.
module line_ram
   import multi_line_buffer_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 512,
   localparam int ADDR_W = clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge i_clk) begin
      if (i_en) begin
         rdata_q <= mem_q[i_addr];
         if (i_we) mem_q[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/multi_line_buffer.sv
// Ring of KERNEL_H-1 line stores producing one KERNEL_H-pixel vertical column per
// accepted pixel, with frame restart and optional zero padding of the top border.
module multi_line_buffer
   import multi_line_buffer_pkg::*;
#(
   parameter  int DATA_W     = 8,
   parameter  int IMG_WIDTH  = 512,
   parameter  int KERNEL_H   = 3,
   parameter  int PAD_EN     = 0,
   localparam int COL_W      = col_w(IMG_WIDTH),
   localparam int FILL_W     = fill_w(KERNEL_H),
   localparam int NUM_STORES = num_stores(KERNEL_H),
   localparam int SEL_W      = clog2(NUM_STORES)
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_sof,
   input  logic [DATA_W-1:0]          i_data,
   input  logic                       i_data_valid,
   output logic [KERNEL_H*DATA_W-1:0] o_data,
   output logic                       o_data_valid,
   output logic [COL_W-1:0]           o_col,
   output logic                       o_eol
);

   logic              accept;
   logic [COL_W-1:0]  col_q, col_d, cur_col;
   logic [FILL_W-1:0] fill_q, fill_d, cur_fill;
   logic [SEL_W-1:0]  sel_q, sel_d, cur_sel;
   logic              last_col;

   logic              vld_q, vld_d;
   logic              live_q, live_d;
   logic [COL_W-1:0]  ocol_q, ocol_d;
   logic              oeol_q, oeol_d;
   logic [FILL_W-1:0] ofill_q, ofill_d;
   logic [SEL_W-1:0]  osel_q, osel_d;
   logic [DATA_W-1:0] pix_q, pix_d;

   logic [DATA_W-1:0]          rd_data [NUM_STORES];
   logic [KERNEL_H*DATA_W-1:0] out_col;

   assign accept = i_data_valid & ~i_rst;

   function automatic logic [SEL_W-1:0] ring_idx(input int sel, input int k);
      int i;
      i = sel + k;
      if (i >= NUM_STORES) i = i - NUM_STORES;
      return SEL_W'(i);
   endfunction

   // Frame tracking: i_sof makes this cycle behave as row 0, column 0.
   always_comb begin
      cur_col  = i_sof ? '0 : col_q;
      cur_fill = i_sof ? '0 : fill_q;
      cur_sel  = i_sof ? '0 : sel_q;
      last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
      col_d    = cur_col;
      fill_d   = cur_fill;
      sel_d    = cur_sel;
      if (accept) begin
         if (last_col) begin
            col_d  = '0;
            sel_d  = (cur_sel == SEL_W'(NUM_STORES - 1)) ? '0 : cur_sel + 1'b1;
            fill_d = (cur_fill == FILL_W'(NUM_STORES)) ? cur_fill : cur_fill + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         col_q  <= '0;
         fill_q <= '0;
         sel_q  <= '0;
      end else begin
         col_q  <= col_d;
         fill_q <= fill_d;
         sel_q  <= sel_d;
      end
   end

   for (genvar s = 0; s < NUM_STORES; s++) begin : g_store
      line_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (IMG_WIDTH)
      ) u_ram (
         .i_clk   (i_clk),
         .i_en    (accept),
         .i_we    (cur_sel == SEL_W'(s)),
         .i_addr  (cur_col),
         .i_wdata (i_data),
         .o_rdata (rd_data[s])
      );
   end

   // Output stage: aligned with the RAM read, updated only on acceptance.
   always_comb begin
      vld_d   = accept & ((PAD_EN != 0) || (cur_fill == FILL_W'(NUM_STORES)));
      live_d  = live_q;
      ocol_d  = ocol_q;
      oeol_d  = oeol_q;
      ofill_d = ofill_q;
      osel_d  = osel_q;
      pix_d   = pix_q;
      if (accept) begin
         live_d  = 1'b1;
         ocol_d  = cur_col;
         oeol_d  = vld_d & last_col;
         ofill_d = cur_fill;
         osel_d  = cur_sel;
         pix_d   = i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q   <= 1'b0;
         live_q  <= 1'b0;
         ocol_q  <= '0;
         oeol_q  <= 1'b0;
         ofill_q <= '0;
         osel_q  <= '0;
      end else begin
         vld_q   <= vld_d;
         live_q  <= live_d;
         ocol_q  <= ocol_d;
         oeol_q  <= oeol_d;
         ofill_q <= ofill_d;
         osel_q  <= osel_d;
      end
      pix_q <= pix_d;
   end

   // Oldest stored row lands in slice 0; rows not yet part of this frame read as zero when padding.
   always_comb begin
      out_col = '0;
      if (live_q) begin
         for (int k = 0; k < NUM_STORES; k++) begin
            if ((PAD_EN == 0) || (k >= NUM_STORES - int'(ofill_q)))
               out_col[k*DATA_W +: DATA_W] = rd_data[ring_idx(int'(osel_q), k)];
         end
         out_col[NUM_STORES*DATA_W +: DATA_W] = pix_q;
      end
   end

   assign o_data       = out_col;
   assign o_data_valid = vld_q;
   assign o_col        = ocol_q;
   assign o_eol        = oeol_q;

endmodule

// File: tb/tb_multi_line_buffer.sv
// Drives an unpadded and a padded instance with the same stream and compares both
// against a line-history model of the frame.
module tb_multi_line_buffer;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int KH = 3;
   localparam int NS = KH - 1;
   localparam int OW = KH * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, sof, vld;
   logic [DW-1:0] din;
   logic [OW-1:0] d0, d1;
   logic          v0, v1, e0, e1;
   logic [1:0]    c0, c1;

   multi_line_buffer #(.DATA_W(DW), .IMG_WIDTH(W), .KERNEL_H(KH), .PAD_EN(0)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_sof(sof), .i_data(din), .i_data_valid(vld),
      .o_data(d0), .o_data_valid(v0), .o_col(c0), .o_eol(e0)
   );

   multi_line_buffer #(.DATA_W(DW), .IMG_WIDTH(W), .KERNEL_H(KH), .PAD_EN(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_sof(sof), .i_data(din), .i_data_valid(vld),
      .o_data(d1), .o_data_valid(v1), .o_col(c1), .o_eol(e1)
   );

   int n_cmp = 0;
   int n_err = 0;
   int n_v0  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: completed lines of the current frame plus the partial line.
   logic [W*DW-1:0] hist [$];
   logic [W*DW-1:0] part;
   int              mcol;
   logic            exp_v0, exp_v1, exp_eol0, exp_eol1, known0;
   logic [OW-1:0]   exp_d0, exp_d1;
   logic [1:0]      exp_col;

   task automatic model_step(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
      logic [W*DW-1:0] line;
      int              j;
      if (r) begin
         hist.delete();
         mcol = 0;
         exp_v0 = 0; exp_v1 = 0; exp_d0 = '0; exp_d1 = '0;
         exp_col = '0; exp_eol0 = 0; exp_eol1 = 0; known0 = 1;
         return;
      end
      if (s) begin
         hist.delete();
         mcol = 0;
      end
      if (!v) begin
         exp_v0 = 0;
         exp_v1 = 0;
         return;
      end
      exp_d1 = '0;
      for (int k = 0; k < NS; k++) begin
         j = k - (NS - hist.size());
         if (j >= 0) begin
            line = hist[j];
            exp_d1[k*DW +: DW] = line[mcol*DW +: DW];
         end
      end
      exp_d1[NS*DW +: DW] = d;
      exp_v1   = 1;
      exp_col  = 2'(mcol);
      exp_eol1 = (mcol == W - 1);
      exp_v0   = (hist.size() == NS);
      if (exp_v0) begin
         exp_d0   = exp_d1;
         exp_eol0 = exp_eol1;
         known0   = 1;
      end else begin
         known0 = 0;
      end
      part[mcol*DW +: DW] = d;
      mcol++;
      if (mcol == W) begin
         hist.push_back(part);
         if (hist.size() > NS) void'(hist.pop_front());
         mcol = 0;
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
      rst = r; sof = s; vld = v; din = d;
      @(posedge clk);
      model_step(r, s, v, d);
      #1;
      check("vld0", 32'(v0), 32'(exp_v0));
      check("vld1", 32'(v1), 32'(exp_v1));
      check("dat1", 32'(d1), 32'(exp_d1));
      check("col1", 32'(c1), 32'(exp_col));
      check("eol1", 32'(e1), 32'(exp_eol1));
      if (known0) begin
         check("dat0", 32'(d0), 32'(exp_d0));
         check("col0", 32'(c0), 32'(exp_col));
         check("eol0", 32'(e0), 32'(exp_eol0));
      end
      if (v0) n_v0++;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic send_row(input logic [DW-1:0] base, input int gap);
      for (int c = 0; c < W; c++) begin
         cyc(1'b0, 1'b0, 1'b1, base + 8'(c));
         repeat (gap) idle();
      end
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      rst = 1'b1; sof = 1'b0; vld = 1'b0; din = '0;
      part = '0; mcol = 0; known0 = 1;
      do_reset();
      check("rst_dat0", 32'(d0), 32'h0);
      check("rst_dat1", 32'(d1), 32'h0);
      check("rst_col0", 32'(c0), 32'h0);
      check("rst_eol0", 32'(e0), 32'h0);

      // Fill and ring wrap, unpadded
      n_v0 = 0;
      send_row(8'h00, 0);
      send_row(8'h10, 0);
      cyc(1'b0, 1'b0, 1'b1, 8'h20);
      check("fill_dat", 32'(d0), 32'h201000);
      check("fill_col", 32'(c0), 32'h0);
      for (int c = 1; c < W; c++) cyc(1'b0, 1'b0, 1'b1, 8'h20 + 8'(c));
      send_row(8'h30, 0);
      send_row(8'h40, 0);
      for (int c = 0; c < W - 1; c++) cyc(1'b0, 1'b0, 1'b1, 8'h50 + 8'(c));
      cyc(1'b0, 1'b0, 1'b1, 8'h53);
      check("wrap_dat", 32'(d0), 32'h534333);
      check("wrap_col", 32'(c0), 32'h3);
      check("wrap_eol", 32'(e0), 32'h1);
      check("n_valid", 32'(n_v0), 32'd16);

      // Idle gaps between pixels
      do_reset();
      send_row(8'h00, 0);
      send_row(8'h10, 0);
      send_row(8'h20, 3);

      // Padded top border
      do_reset();
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h01);
      check("pad_r0", 32'(d1), 32'h010000);
      cyc(1'b0, 1'b0, 1'b1, 8'h02);
      cyc(1'b0, 1'b0, 1'b1, 8'h03);
      cyc(1'b0, 1'b0, 1'b1, 8'h10);
      cyc(1'b0, 1'b0, 1'b1, 8'h11);
      check("pad_r1", 32'(d1), 32'h110100);

      // Frame restart mid-line
      do_reset();
      send_row(8'h00, 0);
      send_row(8'h10, 0);
      send_row(8'h20, 0);
      cyc(1'b0, 1'b0, 1'b1, 8'h30);
      cyc(1'b0, 1'b0, 1'b1, 8'h31);
      cyc(1'b0, 1'b1, 1'b1, 8'hA0);
      check("sof_pad", 32'(d1), 32'hA00000);
      check("sof_vld0", 32'(v0), 32'h0);
      for (int c = 1; c < W; c++) cyc(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(c));
      send_row(8'hB0, 0);
      cyc(1'b0, 1'b0, 1'b1, 8'hC0);
      check("sof_new", 32'(d0), 32'hC0B0A0);

      // Reset while a pixel is presented
      do_reset();
      send_row(8'h00, 0);
      send_row(8'h10, 0);
      send_row(8'h20, 0);
      cyc(1'b0, 1'b0, 1'b1, 8'h30);
      cyc(1'b1, 1'b0, 1'b1, 8'h31);
      check("mrst_vld", 32'(v0), 32'h0);
      check("mrst_dat", 32'(d0), 32'h0);
      check("mrst_col", 32'(c0), 32'h0);
      send_row(8'h00, 0);
      send_row(8'h10, 0);
      cyc(1'b0, 1'b0, 1'b1, 8'h20);
      check("mrst_fill", 32'(d0), 32'h201000);

      // Random traffic with occasional restarts and resets
      repeat (3000) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0),
             ($urandom_range(0, 3) != 0), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
